// File: rtl/dp_tx_packetizer.sv
// GPP-to-link packetizer: buffers GPP words in a FIFO and emits one burst of a
// header packet followed by PAYLOAD_LEN data packets per accepted tx_start.
module dp_tx_packetizer #(
  parameter int DATA_W      = 16,
  parameter int ID_W        = 16,
  parameter int PAYLOAD_LEN = 4,
  parameter int DEPTH       = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      gpp_wr,
  input  logic [DATA_W-1:0]         gpp_wr_data,
  input  logic [ID_W-1:0]           node_id,
  input  logic                      tx_start,
  input  logic [ID_W-1:0]           tx_dest,
  input  logic                      tx_ready,
  output logic                      tx_valid,
  output logic [ID_W+DATA_W-1:0]    tx_packet,
  output logic                      tx_done,
  output logic                      tx_reject,
  output logic                      fifo_full,
  output logic                      fifo_overflow,
  output logic [$clog2(DEPTH):0]    fifo_count,
  output logic                      busy
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;
  localparam int PKT_W = ID_W + DATA_W;
  localparam logic [CW-1:0] LEN_C   = CW'(PAYLOAD_LEN);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // state | meaning
  // IDLE  | waiting for tx_start
  // HDR   | header packet presented on the link
  // PAY   | data packets presented, one FIFO pop per accepted packet
  // DONE  | burst complete, tx_done pulse
  typedef enum logic [1:0] {IDLE, HDR, PAY, DONE} state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_ptr_nx;
  logic [CW-1:0]       count_q, count_d, sent_q, sent_d, sent_inc;
  logic [ID_W-1:0]     dest_q, dest_d;
  logic [PKT_W-1:0]    pkt_q, pkt_d;
  logic                valid_q, valid_d, reject_q, reject_d, ovf_q, ovf_d;
  logic                full, push, pop;
  logic [DATA_W-1:0]   src_ext;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  assign full      = (count_q == DEPTH_C);
  assign rd_ptr_nx = rd_ptr_q + 1'b1;
  assign sent_inc  = sent_q + 1'b1;

  // A pop in the same cycle frees the slot, so a write while full still lands.
  always_comb begin
    push     = gpp_wr && (!full || pop);
    ovf_d    = gpp_wr && full && !pop;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_nx : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_comb begin
    src_ext = '0;
    src_ext[ID_W-1:0] = node_id;
  end

  always_comb begin
    state_d  = state_q;
    dest_d   = dest_q;
    pkt_d    = pkt_q;
    valid_d  = valid_q;
    sent_d   = sent_q;
    reject_d = 1'b0;
    pop      = 1'b0;
    case (state_q)
      IDLE: begin
        if (tx_start) begin
          if (count_q >= LEN_C) begin
            dest_d  = tx_dest;
            pkt_d   = {tx_dest, src_ext};
            valid_d = 1'b1;
            state_d = HDR;
          end else begin
            reject_d = 1'b1;
          end
        end
      end
      HDR: begin
        if (tx_ready) begin
          pkt_d   = {dest_q, mem_q[rd_ptr_q]};
          sent_d  = '0;
          state_d = PAY;
        end
      end
      PAY: begin
        if (tx_ready) begin
          pop    = 1'b1;
          sent_d = sent_inc;
          // Enough words were present at start, so the next slot is always valid.
          if (sent_inc < LEN_C) begin
            pkt_d = {dest_q, mem_q[rd_ptr_nx]};
          end else begin
            pkt_d   = '0;
            valid_d = 1'b0;
            state_d = DONE;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      sent_q   <= '0;
      dest_q   <= '0;
      pkt_q    <= '0;
      valid_q  <= 1'b0;
      reject_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      sent_q   <= sent_d;
      dest_q   <= dest_d;
      pkt_q    <= pkt_d;
      valid_q  <= valid_d;
      reject_q <= reject_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= gpp_wr_data;
  end

  assign tx_valid      = valid_q;
  assign tx_packet     = pkt_q;
  assign tx_done       = (state_q == DONE);
  assign tx_reject     = reject_q;
  assign fifo_full     = full;
  assign fifo_overflow = ovf_q;
  assign fifo_count    = count_q;
  assign busy          = (state_q != IDLE);

endmodule
